// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares a single GCD core among NUM_REQ requesters.
// Zero operands bypass the core; a core that never answers is aborted after TIMEOUT cycles.
module gcd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*WIDTH-1:0]   op_a_i,
  input  logic [NUM_REQ*WIDTH-1:0]   op_b_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic [NUM_REQ-1:0]         err_o,
  output logic [WIDTH-1:0]           result_o,
  output logic                       core_req_o,
  output logic [WIDTH-1:0]           core_a_o,
  output logic [WIDTH-1:0]           core_b_o,
  input  logic                       core_busy_i,
  input  logic                       core_valid_i,
  input  logic [WIDTH-1:0]           core_result_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, grant_q, grant_d, win_idx, nxt_ptr;
  logic [TW-1:0]        timer_q, timer_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic                 core_req_q, core_req_d;
  logic [WIDTH-1:0]     opa [NUM_REQ];
  logic [WIDTH-1:0]     opb [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign opa[i] = op_a_i[i*WIDTH +: WIDTH];
    assign opb[i] = op_b_i[i*WIDTH +: WIDTH];
  end

  // Scan offsets high to low so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    logic [IW-1:0] cand;
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_i[cand]) win_idx = cand;
    end
  end

  assign nxt_ptr = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    timer_d    = timer_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    result_d   = '0;
    ack_d      = '0;
    done_d     = '0;
    err_d      = '0;
    core_req_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_i && !core_busy_i) begin
          grant_d        = win_idx;
          a_d            = opa[win_idx];
          b_d            = opb[win_idx];
          ack_d[win_idx] = 1'b1;
          if (opa[win_idx] == '0 || opb[win_idx] == '0) begin
            res_d   = opa[win_idx] | opb[win_idx];
            state_d = S_DONE;
          end else begin
            core_req_d = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (core_valid_i) begin
          res_d   = core_result_i;
          state_d = S_DONE;
        end else if (timer_q == TW'(TIMEOUT)) begin
          err_d[grant_q] = 1'b1;
          ptr_d          = nxt_ptr;
          a_d            = '0;
          b_d            = '0;
          state_d        = S_IDLE;
        end
      end
      S_DONE: begin
        done_d[grant_q] = 1'b1;
        result_d        = res_q;
        ptr_d           = nxt_ptr;
        a_d             = '0;
        b_d             = '0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      timer_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      result_q   <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      core_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      timer_q    <= timer_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      result_q   <= result_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_req_q <= core_req_d;
    end
  end

  assign ack_o      = ack_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign result_o   = result_q;
  assign core_req_o = core_req_q;
  assign core_a_o   = a_q;
  assign core_b_o   = b_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: directed scenarios plus random traffic against a
// round-robin/Euclid reference model, with a simple latency-programmable core stand-in.
module tb_gcd_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_i;
  logic [15:0] op_a_i, op_b_i;
  logic [3:0]  ack_o, done_o, err_o;
  logic [3:0]  result_o;
  logic        core_req_o;
  logic [3:0]  core_a_o, core_b_o;
  logic        core_busy_i;
  logic        core_valid_i;
  logic [3:0]  core_result_i;

  logic [3:0]  opa_s [4];
  logic [3:0]  opb_s [4];

  int compared = 0;
  int mism     = 0;
  int model_ptr = 0;
  bit core_respond = 1'b1;
  int core_lat = 3;
  int core_cnt = 0;
  logic [3:0] core_pend;

  gcd_arbiter #(.NUM_REQ(4), .WIDTH(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .ack_o(ack_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
    .core_req_o(core_req_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_busy_i(core_busy_i), .core_valid_i(core_valid_i), .core_result_i(core_result_i)
  );

  always #5 clk_i = ~clk_i;

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign op_a_i[i*4 +: 4] = opa_s[i];
    assign op_b_i[i*4 +: 4] = opb_s[i];
  end

  function automatic int gcd_ref(input int a, input int b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  function automatic int model_winner(input logic [3:0] m);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (model_ptr + k) % 4;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  // Core stand-in: answers gcd(core_a, core_b) core_lat cycles after a start pulse.
  always begin
    @(posedge clk_i);
    #1;
    core_valid_i = 1'b0;
    if (!rst_ni) core_cnt = 0;
    else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_valid_i  = 1'b1;
        core_result_i = core_pend;
      end
    end else if (core_req_o && core_respond) begin
      core_pend = 4'(gcd_ref(int'(core_a_o), int'(core_b_o)));
      core_cnt  = core_lat;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_op(input int i, input bit allow_zero);
    opa_s[i] = (allow_zero && $urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    opb_s[i] = (allow_zero && $urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endtask

  // Wait for the next grant, check it against the model, then follow it to done/err.
  task automatic serve(input bit respond, input int lat, output int g);
    int n, eg, exp_r, extra;
    logic [3:0] a, b, oh;
    bit byp;
    core_respond = respond;
    core_lat     = lat;
    n = 0;
    while (!(|ack_o) && n < 40) begin tick(); n++; end
    chk("ack_seen", 32'(|ack_o), 32'd1);
    eg = model_winner(req_i);
    g  = eg;
    if (eg < 0) eg = 0;
    oh = 4'b0001 << eg;
    chk("ack_onehot", 32'(ack_o), 32'(oh));
    a = opa_s[eg];
    b = opb_s[eg];
    chk("core_a", 32'(core_a_o), 32'(a));
    chk("core_b", 32'(core_b_o), 32'(b));
    byp   = (a == 0) || (b == 0);
    exp_r = gcd_ref(int'(a), int'(b));
    chk("core_req_at_ack", 32'(core_req_o), byp ? 32'd0 : 32'd1);
    req_i[eg] = 1'b0;
    tick();
    chk("ack_pulse_end", 32'(ack_o), 32'd0);
    if (!byp) begin
      extra = 0;
      n = 0;
      while (!(|done_o) && !(|err_o) && n < 40) begin
        extra += int'(core_req_o);
        tick();
        n++;
      end
      chk("core_req_single", 32'(extra), 32'd0);
    end
    if (respond || byp) begin
      chk("done_onehot", 32'(done_o), 32'(oh));
      chk("err_quiet", 32'(err_o), 32'd0);
      chk("result", 32'(result_o), 32'(exp_r));
    end else begin
      chk("err_onehot", 32'(err_o), 32'(oh));
      chk("done_quiet", 32'(done_o), 32'd0);
      chk("result_zero", 32'(result_o), 32'd0);
    end
    model_ptr = (eg + 1) % 4;
  endtask

  initial begin
    int g, quiet;
    logic [3:0] m;
    req_i = '0; core_busy_i = 1'b0; core_valid_i = 1'b0; core_result_i = '0;
    for (int i = 0; i < 4; i++) begin opa_s[i] = '0; opb_s[i] = '0; end
    rst_ni = 1'b0;
    repeat (3) tick();
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_result", 32'(result_o), 0);
    chk("rst_core_req", 32'(core_req_o), 0);
    chk("rst_core_ab", {24'd0, core_a_o, core_b_o}, 0);
    rst_ni = 1'b1;
    tick();

    // Round robin: all four held, each re-raised after completion.
    for (int i = 0; i < 4; i++) rand_op(i, 1'b0);
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(1'b1, 2, g);
      chk("rr_order", 32'(g), 32'(i % 4));
      if (i < 4) begin
        rand_op(g, 1'b0);
        req_i[g] = 1'b1;
      end else req_i = '0;
    end
    tick();

    // Single request through the core.
    opa_s[0] = 4'd12; opb_s[0] = 4'd8;
    req_i = 4'b0001;
    serve(1'b1, 3, g);
    chk("single_result", 32'(result_o), 32'd4);

    // Zero bypass.
    opa_s[2] = 4'd0; opb_s[2] = 4'd9;
    req_i = 4'b0100;
    serve(1'b1, 3, g);
    chk("bypass_result", 32'(result_o), 32'd9);
    opa_s[2] = 4'd0; opb_s[2] = 4'd0;
    req_i = 4'b0100;
    serve(1'b1, 3, g);

    // Busy gating.
    rand_op(1, 1'b0);
    req_i = 4'b0010;
    core_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_no_ack", 32'(ack_o), 0);
      chk("busy_no_core_req", 32'(core_req_o), 0);
    end
    core_busy_i = 1'b0;
    tick();
    chk("busy_release_grant", 32'(ack_o), 32'b0010);
    serve(1'b1, 2, g);

    // Timeout then the other pending requester is served.
    rand_op(0, 1'b0); rand_op(3, 1'b0);
    req_i = 4'b1001;
    serve(1'b0, 1, g);
    serve(1'b1, 4, g);
    req_i = '0;

    // Random traffic.
    for (int it = 0; it < 25; it++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) if (m[i]) rand_op(i, 1'b1);
      req_i = m;
      serve(1'b1, int'($urandom_range(1, 6)), g);
      req_i = '0;
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Reset during WAIT: ptr is moved to 3 first so a missing ptr reset is visible.
    opa_s[2] = 4'd0; opb_s[2] = 4'd5;
    req_i = 4'b0100;
    serve(1'b1, 1, g);
    rand_op(3, 1'b0);
    req_i = 4'b1000;
    core_respond = 1'b0;
    while (!(|ack_o)) tick();
    req_i = '0;
    tick(); tick();
    rst_ni = 1'b0;
    #1;
    chk("mrst_ack", 32'(ack_o), 0);
    chk("mrst_done", 32'(done_o), 0);
    chk("mrst_err", 32'(err_o), 0);
    chk("mrst_result", 32'(result_o), 0);
    chk("mrst_core_req", 32'(core_req_o), 0);
    chk("mrst_core_ab", {24'd0, core_a_o, core_b_o}, 0);
    tick(); tick();
    rst_ni = 1'b1;
    model_ptr = 0;
    quiet = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      quiet += int'(|done_o) + int'(|err_o);
    end
    chk("mrst_no_completion", 32'(quiet), 0);
    for (int i = 1; i < 4; i++) rand_op(i, 1'b0);
    req_i = 4'b1110;
    serve(1'b1, 2, g);
    chk("mrst_ptr_zero_grant", 32'(g), 32'd1);
    req_i = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
